// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS main control decoder and the instruction loader:
// primary opcodes, the loader's instruction-class encoding and its FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Codes 6 and 7 are deliberately left out of the enum; they are illegal.
  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_ADDI = 3'd4,
    CLS_J    = 3'd5
  } instrClass_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loaderState_e;

endpackage : mips_pkg

// File: rtl/instr_encoder.sv
// Combinational MIPS encoder: packs instruction-class and field values into a
// 32-bit word; flags classes that the core's control decoder does not support.
module instr_encoder
  import mips_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // Select the field layout by class; shamt is always zero, imm[25:16] only feeds J.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (cls)
      CLS_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      CLS_LW:   word = {OP_LW,   rs, rt, imm[15:0]};
      CLS_SW:   word = {OP_SW,   rs, rt, imm[15:0]};
      CLS_BEQ:  word = {OP_BEQ,  rs, rt, imm[15:0]};
      CLS_ADDI: word = {OP_ADDI, rs, rt, imm[15:0]};
      CLS_J:    word = {OP_J,    imm};
      default:  illegal = 1'b1;
    endcase
  end

endmodule : instr_encoder

// File: rtl/imem_loader.sv
// Sequential instruction-memory writer: accepts decoded instruction beats, encodes
// them and writes one word per accepted beat at consecutive addresses from 0.
module imem_loader
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              error
);

  loaderState_e      stateR, nextStateS;
  logic [ADDR_W-1:0] addrR;
  logic [ADDR_W:0]   countR;
  logic [ADDR_W-1:0] waddrR;
  logic [WIDTH-1:0]  wdataR;
  logic              weR, doneR, errorR, inReadyR;
  logic [31:0]       wordS;
  logic              illegalS, acceptS, writeS, lastAddrS, faultS;

  instr_encoder u_enc (
    .cls     (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .word    (wordS),
    .illegal (illegalS)
  );

  // start outranks a beat presented in the same cycle, so such a beat is dropped.
  assign acceptS   = (stateR == LOAD) && in_valid && !start;
  assign writeS    = acceptS && !illegalS;
  assign lastAddrS = (addrR == {ADDR_W{1'b1}});
  assign faultS    = acceptS && (illegalS || (!in_last && lastAddrS));

  // Next-state selection; start restarts the load from any state.
  always_comb begin
    nextStateS = stateR;
    if (start) begin
      nextStateS = LOAD;
    end else begin
      case (stateR)
        IDLE: nextStateS = IDLE;
        LOAD: begin
          if (!acceptS) begin
            nextStateS = LOAD;
          end else if (faultS) begin
            nextStateS = ERR;
          end else if (in_last) begin
            nextStateS = DONE;
          end else begin
            nextStateS = LOAD;
          end
        end
        DONE:    nextStateS = IDLE;
        ERR:     nextStateS = ERR;
        default: nextStateS = IDLE;
      endcase
    end
  end

  // State, address/count and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR   <= IDLE;
      inReadyR <= 1'b0;
      addrR    <= {ADDR_W{1'b0}};
      countR   <= {(ADDR_W+1){1'b0}};
      waddrR   <= {ADDR_W{1'b0}};
      wdataR   <= {WIDTH{1'b0}};
      weR      <= 1'b0;
      doneR    <= 1'b0;
      errorR   <= 1'b0;
    end else begin
      stateR   <= nextStateS;
      inReadyR <= (nextStateS == LOAD);
      weR      <= writeS;
      doneR    <= writeS && in_last;
      if (start) begin
        addrR  <= {ADDR_W{1'b0}};
        countR <= {(ADDR_W+1){1'b0}};
        errorR <= 1'b0;
      end else begin
        if (writeS) begin
          addrR  <= addrR + ADDR_W'(1);
          countR <= countR[ADDR_W] ? countR : countR + (ADDR_W+1)'(1);
          waddrR <= addrR;
          wdataR <= wordS;
        end
        errorR <= errorR | faultS;
      end
    end
  end

  assign in_ready   = inReadyR;
  assign imem_we    = weR;
  assign imem_addr  = waddrR;
  assign imem_wdata = wdataR;
  assign count      = countR;
  assign done       = doneR;
  assign error      = errorR;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench: a deep (ADDR_W=8) and a shallow (ADDR_W=2) loader share one
// stimulus stream; each is compared every cycle against a transaction-level model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, inValid, inLast;
  logic [2:0]  inOp;
  logic [4:0]  inRs, inRt, inRd;
  logic [5:0]  inFunct;
  logic [25:0] inImm;

  logic [1:0]  rdy, we, dn, er;
  logic [7:0]  addrA;
  logic [1:0]  addrB;
  logic [31:0] wdA, wdB;
  logic [8:0]  cntA;
  logic [2:0]  cntB;

  int testsRun = 0;
  int testsFailed = 0;

  imem_loader #(.WIDTH(32), .ADDR_W(8)) dutA (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_ready(rdy[0]),
    .in_last(inLast), .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd),
    .in_funct(inFunct), .in_imm(inImm), .imem_we(we[0]), .imem_addr(addrA),
    .imem_wdata(wdA), .count(cntA), .done(dn[0]), .error(er[0])
  );

  imem_loader #(.WIDTH(32), .ADDR_W(2)) dutB (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid), .in_ready(rdy[1]),
    .in_last(inLast), .in_op(inOp), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd),
    .in_funct(inFunct), .in_imm(inImm), .imem_we(we[1]), .imem_addr(addrB),
    .imem_wdata(wdB), .count(cntB), .done(dn[1]), .error(er[1])
  );

  always #5 clk = ~clk;

  // Reference model: a loader is either accepting or not, and keeps a write pointer.
  int          depth [2] = '{256, 4};
  bit          act [2];
  int          nAddr [2];
  int          cnt [2];
  bit          eWe [2];
  bit          eDone [2];
  bit          eErr [2];
  int          eAddr [2];
  logic [31:0] eData [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct, input logic [25:0] imm);
    case (op)
      3'd0: return {6'b000000, rs, rt, rd, 5'b00000, funct};
      3'd1: return {6'b100011, rs, rt, imm[15:0]};
      3'd2: return {6'b101011, rs, rt, imm[15:0]};
      3'd3: return {6'b000100, rs, rt, imm[15:0]};
      3'd4: return {6'b001000, rs, rt, imm[15:0]};
      default: return {6'b000010, imm};
    endcase
  endfunction

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        act[i] = 0; nAddr[i] = 0; cnt[i] = 0;
        eWe[i] = 0; eDone[i] = 0; eErr[i] = 0; eAddr[i] = 0; eData[i] = 32'h0;
      end else begin
        eWe[i] = 0;
        eDone[i] = 0;
        if (start) begin
          act[i] = 1; nAddr[i] = 0; cnt[i] = 0; eErr[i] = 0;
        end else if (act[i] && inValid) begin
          if (inOp > 3'd5) begin
            eErr[i] = 1; act[i] = 0;
          end else begin
            eWe[i] = 1;
            eAddr[i] = nAddr[i];
            eData[i] = encode(inOp, inRs, inRt, inRd, inFunct, inImm);
            nAddr[i] = (nAddr[i] + 1) % depth[i];
            if (cnt[i] < depth[i]) cnt[i]++;
            if (inLast) begin
              eDone[i] = 1; act[i] = 0;
            end else if (eAddr[i] == depth[i] - 1) begin
              eErr[i] = 1; act[i] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(act[i]));
      check($sformatf("imem_we[%0d]", i), 32'(we[i]), 32'(eWe[i]));
      check($sformatf("done[%0d]", i), 32'(dn[i]), 32'(eDone[i]));
      check($sformatf("error[%0d]", i), 32'(er[i]), 32'(eErr[i]));
      check($sformatf("count[%0d]", i), (i == 0) ? 32'(cntA) : 32'(cntB), 32'(cnt[i]));
      check($sformatf("imem_addr[%0d]", i), (i == 0) ? 32'(addrA) : 32'(addrB), 32'(eAddr[i]));
      check($sformatf("imem_wdata[%0d]", i), (i == 0) ? wdA : wdB, eData[i]);
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    compareAll();
  endtask

  task automatic idleIn();
    reset = 1'b0; start = 1'b0; inValid = 1'b0; inLast = 1'b0; inOp = 3'd0;
    inRs = 5'd0; inRt = 5'd0; inRd = 5'd0; inFunct = 6'd0; inImm = 26'd0;
  endtask

  task automatic beat(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] funct, input logic [25:0] imm, input logic last);
    start = 1'b0; inValid = 1'b1; inLast = last; inOp = op;
    inRs = rs; inRt = rt; inRd = rd; inFunct = funct; inImm = imm;
  endtask

  task automatic pulseStart();
    idleIn(); start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    idleIn();
    reset = 1'b1;
    tick(); tick();
    check("reset_we", 32'(we[0]), 32'd0);
    check("reset_addr", 32'(addrA), 32'd0);
    check("reset_count", 32'(cntA), 32'd0);
    idleIn();
    tick();

    // Three-instruction program ending on J
    pulseStart();
    beat(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'd0, 1'b0); tick();
    check("r_word", wdA, 32'h00221820);
    check("r_addr", 32'(addrA), 32'd0);
    beat(3'd1, 5'd0, 5'd4, 5'd0, 6'd0, 26'h0008, 1'b0); tick();
    check("lw_word", wdA, 32'h8C040008);
    beat(3'd5, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0000010, 1'b1); tick();
    check("j_word", wdA, 32'h08000010);
    check("j_addr", 32'(addrA), 32'd2);
    check("j_done", 32'(dn[0]), 32'd1);
    check("j_count", 32'(cntA), 32'd3);
    check("j_ready", 32'(rdy[0]), 32'd0);
    idleIn(); tick();
    check("after_done", 32'(dn[0]), 32'd0);

    // ADDI ignores imm[25:16]
    pulseStart();
    beat(3'd4, 5'd5, 5'd5, 5'd0, 6'd0, 26'h3FFFFFF, 1'b1); tick();
    check("addi_word", wdA, 32'h20A5FFFF);
    idleIn(); tick();

    // Illegal op on second beat, then recovery
    pulseStart();
    beat(3'd0, 5'd7, 5'd8, 5'd9, 6'h22, 26'd0, 1'b0); tick();
    beat(3'd6, 5'd1, 5'd1, 5'd1, 6'd1, 26'd1, 1'b0); tick();
    check("ill_we", 32'(we[0]), 32'd0);
    check("ill_error", 32'(er[0]), 32'd1);
    check("ill_ready", 32'(rdy[0]), 32'd0);
    idleIn(); tick(); tick();
    check("ill_sticky", 32'(er[0]), 32'd1);
    pulseStart();
    check("ill_cleared", 32'(er[0]), 32'd0);
    beat(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 26'h1234, 1'b1); tick();
    check("ill_restart_addr", 32'(addrA), 32'd0);
    check("ill_restart_word", wdA, 32'hAC641234);
    idleIn(); tick();

    // Overflow on the shallow instance: five beats, four writes
    pulseStart();
    for (int k = 0; k < 5; k++) begin
      beat(3'd3, 5'(k), 5'(k + 1), 5'd0, 6'd0, 26'(k), 1'b0); tick();
      if (k == 3) check("ovf_last_addr", 32'(addrB), 32'd3);
    end
    check("ovf_we", 32'(we[1]), 32'd0);
    check("ovf_error", 32'(er[1]), 32'd1);
    check("ovf_count", 32'(cntB), 32'd4);
    check("ovf_ready", 32'(rdy[1]), 32'd0);
    idleIn(); tick();

    // start coincident with a valid beat discards the beat
    pulseStart();
    beat(3'd0, 5'd1, 5'd1, 5'd1, 6'h24, 26'd0, 1'b0); tick();
    beat(3'd1, 5'd9, 5'd9, 5'd0, 6'd0, 26'h00FF, 1'b0); start = 1'b1; tick();
    check("start_drop_we", 32'(we[0]), 32'd0);
    beat(3'd3, 5'd2, 5'd6, 5'd0, 6'd0, 26'h0004, 1'b1); tick();
    check("start_drop_addr", 32'(addrA), 32'd0);
    check("start_drop_word", wdA, 32'h10460004);
    idleIn(); tick();

    // Reset in the write cycle of an accepted beat
    pulseStart();
    beat(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h0042, 1'b0); tick();
    check("rst_pre_we", 32'(we[0]), 32'd1);
    beat(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 26'h0043, 1'b0); reset = 1'b1; tick();
    check("rst_we", 32'(we[0]), 32'd0);
    check("rst_wdata", wdA, 32'd0);
    check("rst_ready", 32'(rdy[0]), 32'd0);
    idleIn(); tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      reset   = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 39) == 0);
      inValid = ($urandom_range(0, 9) < 7);
      inLast  = ($urandom_range(0, 9) == 0);
      inOp    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      inRs    = 5'($urandom);
      inRt    = 5'($urandom);
      inRd    = 5'($urandom);
      inFunct = 6'($urandom);
      inImm   = 26'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_imem_loader
